// File: rtl/dco_enc_pkg.sv
// rtl/dco_enc_pkg.sv - shared widths, code field layout and FSM state type for the DCO code encoder
package dco_enc_pkg;

  localparam int DCO_ROW_W  = 19;  // row thermometer width
  localparam int DCO_COL_W  = 14;  // fine column thermometer width (fine[13:0])
  localparam int OVF_W      = 15;  // fine overflow group width (fine[29:15])

  localparam int CODE_W     = 13;
  localparam int COARSE_W   = 5;
  localparam int COLUMN_W   = 4;
  localparam int FRAC_W     = 4;
  localparam int COARSE_LSB = 8;
  localparam int COL_LSB    = 4;
  localparam int FRAC_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // True when two fractional fields are more than one LSB apart.
  function automatic logic frac_far(input logic [FRAC_W-1:0] a, input logic [FRAC_W-1:0] b);
    logic [FRAC_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d > 4'd1);
  endfunction

endpackage

// File: rtl/dco_code_encoder_therm2bin.sv
// rtl/dco_code_encoder_therm2bin.sv - combinational thermometer to binary encoder with bubble detect
//
// Ports:
//   therm  [WIDTH-1:0]  thermometer input, ones fill from the LSB
//   count  [CNT_W-1:0]  number of contiguous ones starting at bit 0
//   bubble              a one exists above the first zero
module therm2bin #(
  parameter int WIDTH = 19,
  parameter int CNT_W = 5
) (
  input  logic [WIDTH-1:0] therm,
  output logic [CNT_W-1:0] count,
  output logic             bubble
);

  logic seen_zero;

  // Walk up from the LSB: ones before the first zero count, ones after it
  // are bubbles and leave the count untouched.
  always_comb begin
    count     = '0;
    bubble    = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!seen_zero) begin
        if (therm[i]) begin
          count = count + 1'b1;
        end else begin
          seen_zero = 1'b1;
        end
      end else if (therm[i]) begin
        bubble = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dco_code_encoder.sv
// rtl/dco_code_encoder.sv - readback of the applied DCO row/fine controls as a 13-bit filter-format code
//
// Optional feature macro: DCO_ENC_MISMATCH_EN (adds expected_code input and mismatch output).
//
// Ports:
//   dco_clk        DCO clock, all state on rising edge
//   reset2         asynchronous active-low reset
//   start          single-cycle measurement request (ignored while busy)
//   rows           row thermometer control
//   fine           [29:15] overflow group, [14] DSM bit, [13:0] column thermometer
//   expected_code  code to compare against (DCO_ENC_MISMATCH_EN only)
//   code_out       {coarse[4:0], column[3:0], frac[3:0]}, held until the next DONE
//   code_valid     one-cycle pulse when code_out is updated
//   busy           measurement in progress
//   therm_err      bubble seen in rows or fine[13:0] at capture
//   sat            overflow group was all ones at capture
//   mismatch       code_out disagrees with expected_code (DCO_ENC_MISMATCH_EN only)
module dco_code_encoder
  import dco_enc_pkg::*;
#(
  parameter int WIN_LOG2 = 6,
  parameter int ROW_W    = DCO_ROW_W,
  parameter int COL_W    = DCO_COL_W
) (
  input  logic                     dco_clk,
  input  logic                     reset2,
  input  logic                     start,
  input  logic [ROW_W-1:0]         rows,
  input  logic [COL_W+OVF_W:0]     fine,
`ifdef DCO_ENC_MISMATCH_EN
  input  logic [CODE_W-1:0]        expected_code,
  output logic                     mismatch,
`endif
  output logic [CODE_W-1:0]        code_out,
  output logic                     code_valid,
  output logic                     busy,
  output logic                     therm_err,
  output logic                     sat
);

  // The accumulator needs one extra bit so a window of all ones (count == N)
  // is representable and can be saturated rather than wrapping to zero.
  localparam int ACC_W = WIN_LOG2 + 1;
  localparam int SHIFT = WIN_LOG2 - 4;

  state_t               state;
  logic [WIN_LOG2-1:0]  win_cnt;
  logic [ACC_W-1:0]     acc;
  logic [COARSE_W-1:0]  coarse_q;
  logic [COLUMN_W-1:0]  column_q;
`ifdef DCO_ENC_MISMATCH_EN
  logic [CODE_W-1:0]    expected_q;
`endif

  logic [COARSE_W-1:0]  row_count;
  logic [COLUMN_W-1:0]  col_count;
  logic                 row_bubble;
  logic                 col_bubble;
  logic                 ovf_all;
  logic [ACC_W-1:0]     acc_shr;
  logic [FRAC_W-1:0]    frac_c;
  logic [CODE_W-1:0]    code_c;

  therm2bin #(
    .WIDTH (ROW_W),
    .CNT_W (COARSE_W)
  ) u_row_enc (
    .therm  (rows),
    .count  (row_count),
    .bubble (row_bubble)
  );

  therm2bin #(
    .WIDTH (COL_W),
    .CNT_W (COLUMN_W)
  ) u_col_enc (
    .therm  (fine[COL_W-1:0]),
    .count  (col_count),
    .bubble (col_bubble)
  );

  assign ovf_all = &fine[COL_W+OVF_W:COL_W+1];

  // Mean DSM duty in 1/16 steps; a full window of ones lands on 16 and clips to 15.
  assign acc_shr = acc >> SHIFT;
  assign frac_c  = (acc_shr > ACC_W'(15)) ? 4'hF : acc_shr[FRAC_W-1:0];

  always_comb begin
    code_c                            = '0;
    code_c[COARSE_LSB +: COARSE_W]    = coarse_q;
    code_c[COL_LSB    +: COLUMN_W]    = column_q;
    code_c[FRAC_LSB   +: FRAC_W]      = frac_c;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge dco_clk or negedge reset2) begin
    if (!reset2) begin
      state      <= IDLE;
      win_cnt    <= '0;
      acc        <= '0;
      coarse_q   <= '0;
      column_q   <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      therm_err  <= 1'b0;
      sat        <= 1'b0;
`ifdef DCO_ENC_MISMATCH_EN
      expected_q <= '0;
      mismatch   <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SAMPLE;
            therm_err <= 1'b0;
            sat       <= 1'b0;
            acc       <= '0;
            win_cnt   <= '0;
`ifdef DCO_ENC_MISMATCH_EN
            mismatch  <= 1'b0;
`endif
          end
        end
        SAMPLE: begin
          coarse_q  <= row_count;
          // An overflowed fine group means the column field is meaningless; flag it as all ones.
          column_q  <= ovf_all ? 4'hF : col_count;
          therm_err <= row_bubble | col_bubble;
          sat       <= ovf_all;
`ifdef DCO_ENC_MISMATCH_EN
          expected_q <= expected_code;
`endif
          state     <= ACCUM;
        end
        ACCUM: begin
          acc     <= acc + ACC_W'(fine[COL_W]);
          win_cnt <= win_cnt + 1'b1;
          if (win_cnt == '1) begin
            state <= DONE;
          end
        end
        DONE: begin
          code_out   <= code_c;
          code_valid <= 1'b1;
`ifdef DCO_ENC_MISMATCH_EN
          mismatch   <= (code_c[CODE_W-1:COL_LSB] != expected_q[CODE_W-1:COL_LSB]) ||
                        frac_far(frac_c, expected_q[FRAC_W-1:0]);
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
